// File: rtl/dff_pkg.sv
// Shared definitions for the word-wide D flip-flop register used across the FIR datapath.
package dff_pkg;

   localparam int DFF_WIDTH_DEFAULT = 32;

   typedef logic [DFF_WIDTH_DEFAULT-1:0] dff_word_t;

   localparam dff_word_t DFF_RST_VAL_DEFAULT = '0;

endpackage : dff_pkg

// File: rtl/dff_bit.sv
// Single-bit flop with synchronous active-low reset and a per-instance reset value.
module dff_bit #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   // Reset has priority over d and is only seen at the rising edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= RST_VAL;
      end else begin
         q <= d;
      end
   end

endmodule : dff_bit

// File: rtl/dff_32bit.sv
// WIDTH-bit register built from dff_bit flops; optional even-parity flop via DFF_32BIT_PARITY_EN.
module dff_32bit
   import dff_pkg::*;
#(
   parameter int               WIDTH   = DFF_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_RST_VAL_DEFAULT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
`ifdef DFF_32BIT_PARITY_EN
   output logic             q_par,
`endif
   output logic [WIDTH-1:0] q
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_bit #(
         .RST_VAL (RST_VAL[i])
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .d     (d[i]),
         .q     (q[i])
      );
   end

`ifdef DFF_32BIT_PARITY_EN
   // Loaded from ^d on the same edges as q, so q_par tracks ^q without a path from q.
   dff_bit #(
      .RST_VAL (^RST_VAL)
   ) u_par (
      .clk   (clk),
      .reset (reset),
      .d     (^d),
      .q     (q_par)
   );
`endif

endmodule : dff_32bit

// File: tb/tb_dff_32bit.sv
// Self-checking bench for dff_32bit: directed cases plus random stimulus against a reference model.
module tb_dff_32bit;

   logic        clk;
   logic        reset;
   logic [31:0] d;
   logic [31:0] q;
   logic [7:0]  d8;
   logic [7:0]  q8;
`ifdef DFF_32BIT_PARITY_EN
   logic        q_par;
   logic        q8_par;
`endif

   logic [31:0] exp_q;
   logic [7:0]  exp_q8;
   int          num_checks;
   int          num_errors;

   dff_32bit u_dut (
      .clk   (clk),
      .reset (reset),
      .d     (d),
`ifdef DFF_32BIT_PARITY_EN
      .q_par (q_par),
`endif
      .q     (q)
   );

   dff_32bit #(
      .WIDTH   (8),
      .RST_VAL (8'hA5)
   ) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .d     (d8),
`ifdef DFF_32BIT_PARITY_EN
      .q_par (q8_par),
`endif
      .q     (q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      num_checks++;
      if (got !== want) begin
         num_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_q"}, q, exp_q);
      check({tag, "_q8"}, {24'd0, q8}, {24'd0, exp_q8});
`ifdef DFF_32BIT_PARITY_EN
      check({tag, "_par"}, {31'd0, q_par}, {31'd0, 1'($countones(exp_q) % 2)});
      check({tag, "_par8"}, {31'd0, q8_par}, {31'd0, 1'($countones(exp_q8) % 2)});
`endif
   endtask

   // Apply inputs, take one rising edge, update the model, then sample 1 time unit later.
   task automatic cycle(input logic r, input logic [31:0] dv, input logic [7:0] dv8, input string tag);
      reset = r;
      d     = dv;
      d8    = dv8;
      @(posedge clk);
      exp_q  = r ? dv  : 32'd0;
      exp_q8 = r ? dv8 : 8'hA5;
      #1;
      check_outputs(tag);
   endtask

   initial begin
      num_checks = 0;
      num_errors = 0;
      reset = 1'b0;
      d     = 32'd0;
      d8    = 8'd0;
      @(negedge clk);

      cycle(1'b0, 32'd0,          8'h00, "reset");
      cycle(1'b0, 32'hFFFF_FFFF,  8'hFF, "reset_hold");
      cycle(1'b1, 32'h00BC_614E,  8'h3C, "load");
      check("load_lit", q, 32'd12345678);
      check("load8_lit", {24'd0, q8}, 32'h0000_003C);

      // d changes before the edge must not show on q.
      d = 32'h0539_7FB1;
      #3;
      check("hold_before_edge", q, 32'd12345678);
      cycle(1'b1, 32'h0539_7FB1,  8'hC3, "update");
      check("update_lit", q, 32'd87654321);

      // Drop reset and change d mid-cycle: q must stay until the next edge.
      #2;
      d     = 32'h1234_5678;
      reset = 1'b0;
      #1;
      check("no_async", q, 32'd87654321);
      check("no_async8", {24'd0, q8}, 32'h0000_00C3);
      cycle(1'b0, 32'h1234_5678,  8'h77, "async_then_edge");

      cycle(1'b1, 32'hCAFE_0001,  8'h11, "reload");
      cycle(1'b0, 32'hDEAD_BEEF,  8'h5A, "priority");
      cycle(1'b1, 32'hDEAD_BEEF,  8'h5A, "after_priority");

      for (int i = 0; i < 200; i++) begin
         cycle(($urandom_range(7, 0) != 0) ? 1'b1 : 1'b0,
               32'($urandom), 8'($urandom), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule : tb_dff_32bit
